// File: rtl/seq_restoring_divider_pkg.sv
// seq_restoring_divider_pkg: shared FSM encoding, default width and counter sizing for the divider
package seq_restoring_divider_pkg;
  localparam int WIDTH_DEF = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int cnt_bits(input int width);
    return $clog2(width + 1);
  endfunction
endpackage

// File: rtl/seq_restoring_divider_if.sv
// seq_restoring_divider_if: operand and result valid/ready channels of the divider
interface seq_restoring_divider_if
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic               in_valid;
  logic               in_ready;
  logic [2*WIDTH-1:0] dividend;
  logic [WIDTH-1:0]   divisor;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]   remainder;
  logic               ovf;
  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, ovf
  );
  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, ovf
  );
endinterface

// File: rtl/seq_restoring_divider_step.sv
// seq_restoring_divider_step: one restoring step, shift in a dividend bit, trial-subtract, restore on borrow
module seq_restoring_divider_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] r,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_nx,
  output logic             qbit
);
  logic [WIDTH:0]   t;
  logic [WIDTH:0]   db;
  logic [WIDTH+1:0] c;
  logic [WIDTH-1:0] s;
  assign t    = {r, q_msb};
  assign db   = ~{1'b0, d};
  assign c[0] = 1'b1;
  // t - d as t + ~d + 1 through a full-adder ripple; carry-out high means no borrow
  for (genvar i = 0; i <= WIDTH; i++) begin : g_carry
    assign c[i+1] = (t[i] & db[i]) | (c[i] & (t[i] ^ db[i]));
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_sum
    assign s[i] = t[i] ^ db[i] ^ c[i];
  end
  assign qbit = c[WIDTH+1];
  assign r_nx = qbit ? s : t[WIDTH-1:0];
endmodule

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: iterative restoring divider, 2W-bit by W-bit, one quotient bit per clock
// Define FAST_OVF_EN to finish overflowing divisions at the accepting edge instead of after W steps.
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic clk,
  input logic rst_n,
  seq_restoring_divider_if.slave bus
);
  localparam int CW = cnt_bits(WIDTH);
  state_t           state, state_nx;
  logic [WIDTH-1:0] r, r_nx, q, d, hi;
  logic [CW-1:0]    cnt;
  logic             ovf_r, rdy, qbit, accept, ovf_in, fast_ovf;
  assign hi     = bus.dividend[2*WIDTH-1:WIDTH];
  assign ovf_in = hi >= bus.divisor;
  assign accept = bus.in_valid & rdy;
`ifdef FAST_OVF_EN
  assign fast_ovf = ovf_in;
`else
  assign fast_ovf = 1'b0;
`endif
  seq_restoring_divider_step #(.WIDTH(WIDTH)) u_step (
    .r     (r),
    .q_msb (q[WIDTH-1]),
    .d     (d),
    .r_nx  (r_nx),
    .qbit  (qbit)
  );
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = fast_ovf ? DONE : RUN;
      RUN:     if (cnt == CW'(1)) state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rdy   <= 1'b0;
      r     <= '0;
      q     <= '0;
      d     <= '0;
      cnt   <= '0;
      ovf_r <= 1'b0;
    end else begin
      state <= state_nx;
      rdy   <= state_nx == IDLE;
      if (accept) begin
        d     <= bus.divisor;
        r     <= hi;
        q     <= bus.dividend[WIDTH-1:0];
        cnt   <= CW'(WIDTH);
        ovf_r <= ovf_in;
      end else if (state == RUN) begin
        cnt <= cnt - 1'b1;
        // an overflowing division freezes q so it still holds the low dividend half at DONE
        if (!ovf_r) begin
          r <= r_nx;
          q <= {q[WIDTH-2:0], qbit};
        end
      end
    end
  end
  assign bus.in_ready  = rdy;
  assign bus.out_valid = state == DONE;
  assign bus.quotient  = state != DONE ? '0 : ovf_r ? '1 : q;
  assign bus.remainder = state != DONE ? '0 : ovf_r ? q : r;
  assign bus.ovf       = (state == DONE) & ovf_r;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: directed and exhaustive random-backpressure checks against an arithmetic model
module tb_seq_restoring_divider;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   failed = 0;
  seq_restoring_divider_if #(.WIDTH(W)) bus ();
  seq_restoring_divider #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic do_div(input logic [2*W-1:0] a, input logic [W-1:0] b, input int hold);
    logic [W-1:0] eq, er;
    logic eo;
    int lat, n;
    eo = a[2*W-1:W] >= b;
    if (eo) begin
      eq = '1;
      er = a[W-1:0];
    end else begin
      eq = W'(a / b);
      er = W'(a % b);
    end
    lat = W;
`ifdef FAST_OVF_EN
    if (eo) lat = 0;
`endif
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_wait", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.dividend = 8'($urandom);
    bus.divisor  = 4'($urandom);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("edges_to_valid", 32'(n), 32'(lat));
    check("quotient", 32'(bus.quotient), 32'(eq));
    check("remainder", 32'(bus.remainder), 32'(er));
    check("ovf", 32'(bus.ovf), 32'(eo));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.dividend = 8'($urandom);
      bus.divisor  = 4'($urandom);
      @(posedge clk); #1;
      check("hold", {bus.out_valid, bus.in_ready, bus.quotient, bus.remainder, bus.ovf},
            {1'b1, 1'b0, eq, er, eo});
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("handoff", {bus.out_valid, bus.in_ready}, {1'b0, 1'b1});
  endtask
  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_quotient", 32'(bus.quotient), 32'd0);
    check("rst_remainder", 32'(bus.remainder), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    rst_n = 1'b1;
    #1;
    check("release_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    check("first_edge_in_ready", 32'(bus.in_ready), 32'd1);
    do_div(8'd100, 4'd7, 0);
    do_div(8'd225, 4'd15, 0);
    do_div(8'd15, 4'd15, 0);
    do_div(8'd0, 4'd9, 0);
    do_div(8'd200, 4'd3, 0);
    do_div(8'd5, 4'd0, 0);
    do_div(8'd100, 4'd7, 5);
    do_div(8'd200, 4'd3, 5);
    bus.in_valid = 1'b1;
    bus.dividend = 8'd100;
    bus.divisor  = 4'd7;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("abort", {bus.out_valid, bus.in_ready, bus.quotient, bus.remainder, bus.ovf}, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("abort_release", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    do_div(8'd100, 4'd7, 0);
    for (int a = 0; a < 256; a++)
      for (int b = 0; b < 16; b++)
        do_div(8'(a), 4'(b), int'($urandom_range(0, 2)));
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
